// File: rtl/sweep_ctrl_pkg.sv
// Shared types and default widths for the sweep controller.
package sweep_ctrl_pkg;

  localparam int unsigned SWEEP_W  = 8;
  localparam int unsigned SWEEP_CW = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN_UP   = 3'd2,
    ST_RUN_DOWN = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_LOAD) || (s == ST_RUN_UP) || (s == ST_RUN_DOWN);
  endfunction

endpackage

// File: rtl/sweep_ctrl.sv
// Sweep controller: drives an external up/down counter through triangle
// sweeps between latched lo/hi bounds, for a fixed or unbounded sweep count.
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int unsigned W  = SWEEP_W,
  parameter int unsigned CW = SWEEP_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [CW-1:0] cycles,
  input  logic [W-1:0]  cnt_q,
  output logic          cnt_load,
  output logic [W-1:0]  cnt_data,
  output logic          cnt_en,
  output logic          up_down,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] sweep_cnt
);

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic [CW-1:0] r_cycles;
  logic [CW-1:0] r_sweep_cnt;

  logic r_cnt_load, r_cnt_en, r_up_down, r_busy, r_done, r_err;
  logic w_cnt_load, w_cnt_en, w_up_down, w_busy, w_done, w_err;

  logic w_start_ok;
  logic w_up_turn;
  logic w_down_turn;
  logic w_last_sweep;

  assign w_start_ok   = start && (lo < hi);
  assign w_up_turn    = (cnt_q == r_hi - W'(1));
  assign w_down_turn  = (cnt_q == r_lo + W'(1));
  assign w_last_sweep = (r_cycles != '0) && ((r_sweep_cnt + CW'(1)) == r_cycles);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; stop overrides every busy-state transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start_ok) w_state_next = ST_LOAD;
      ST_LOAD:     w_state_next = stop ? ST_IDLE : ST_RUN_UP;
      ST_RUN_UP: begin
        if (stop)           w_state_next = ST_IDLE;
        else if (w_up_turn) w_state_next = ST_RUN_DOWN;
      end
      ST_RUN_DOWN: begin
        if (stop)             w_state_next = ST_IDLE;
        else if (w_down_turn) w_state_next = w_last_sweep ? ST_DONE : ST_RUN_UP;
      end
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs track the state
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_up_down  = 1'b1;
    w_busy     = is_busy(w_state_next);
    w_done     = 1'b0;
    w_err      = (r_state == ST_IDLE) && start && !(lo < hi);
    case (w_state_next)
      ST_LOAD:     w_cnt_load = 1'b1;
      ST_RUN_UP:   w_cnt_en   = 1'b1;
      ST_RUN_DOWN: begin
        w_cnt_en  = 1'b1;
        w_up_down = 1'b0;
      end
      ST_DONE:     w_done     = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_load <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_up_down  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt_load <= w_cnt_load;
      r_cnt_en   <= w_cnt_en;
      r_up_down  <= w_up_down;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  // Bound latch and sweep counter; a sweep completes even if stop lands on it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo        <= '0;
      r_hi        <= '0;
      r_cycles    <= '0;
      r_sweep_cnt <= '0;
    end else if ((r_state == ST_IDLE) && w_start_ok) begin
      r_lo        <= lo;
      r_hi        <= hi;
      r_cycles    <= cycles;
      r_sweep_cnt <= '0;
    end else if ((r_state == ST_RUN_DOWN) && w_down_turn) begin
      r_sweep_cnt <= r_sweep_cnt + CW'(1);
    end
  end

  assign cnt_load  = r_cnt_load;
  assign cnt_data  = r_lo;
  assign cnt_en    = r_cnt_en;
  assign up_down   = r_up_down;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign sweep_cnt = r_sweep_cnt;

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter W, default 8, count/data width.
REQ-002 Parameter CW, default 4, sweep-count width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-005 start  in  1  request to begin a sweep run; sampled in IDLE only.
REQ-006 stop  in  1  abort request; sampled in any busy state.
REQ-007 lo, hi  in  W each  sweep bounds; latched at accepted start.
REQ-008 cycles  in  CW  number of up/down sweeps; 0 means run until stop; latched at accepted start.
REQ-009 cnt_q  in  W  present value of the controlled up/down counter.
REQ-010 cnt_load  out  1  counter load strobe; counter takes cnt_data on the next edge.
REQ-011 cnt_data  out  W  counter load value.
REQ-012 cnt_en  out  1  counter step enable.
REQ-013 up_down  out  1  counter direction; 1 = increment, 0 = decrement.
REQ-014 busy  out  1  high in LOAD, RUN_UP and RUN_DOWN.
REQ-015 done  out  1  one-cycle pulse on normal completion.
REQ-016 err  out  1  one-cycle pulse on rejected start.
REQ-017 sweep_cnt  out  CW  completed sweeps in the current or last run.

Function
REQ-018 FSM states: IDLE, LOAD, RUN_UP, RUN_DOWN, DONE; all outputs are registered or decoded from state only (Moore).
REQ-019 IDLE, start=1, lo<hi: latch lo/hi/cycles, clear sweep_cnt, go to LOAD.
REQ-020 IDLE, start=1, lo>=hi: err=1 for the next cycle, stay in IDLE, no latch.
REQ-021 LOAD: cnt_load=1, cnt_data=lo_latched, cnt_en=0; next state is RUN_UP.
REQ-022 RUN_UP: cnt_en=1, up_down=1; if cnt_q==hi-1, go to RUN_DOWN.
REQ-023 RUN_DOWN: cnt_en=1, up_down=0; if cnt_q==lo+1, increment sweep_cnt.
REQ-024 RUN_DOWN exit: if cycles!=0 and sweep_cnt+1==cycles, go to DONE; otherwise go to RUN_UP.
REQ-025 One sweep is exactly 2*(hi-lo) enabled cycles; hi-lo=1 is legal (alternates lo, hi).
REQ-026 DONE: done=1, cnt_en=0, cnt_q held at lo; next state is IDLE.
REQ-027 stop=1 in LOAD, RUN_UP or RUN_DOWN: go to IDLE next edge, cnt_en=0 from then on, no done, sweep_cnt frozen.
REQ-028 stop coinciding with the terminal RUN_DOWN condition: stop wins, no done, sweep_cnt still increments.
REQ-029 start while busy: ignored; stop while IDLE: ignored; start and stop together in IDLE: start accepted.
REQ-030 cycles=0: sweep_cnt wraps modulo 2^CW; no done is ever produced.
REQ-031 Bound comparisons use latched values; changing lo, hi or cycles mid-run has no effect.
REQ-032 Outside RUN_UP/RUN_DOWN: cnt_en=0 and up_down=1; cnt_load=1 only in LOAD.

Reset
REQ-033 On reset assertion, asynchronously: state=IDLE, cnt_load=0, cnt_data=0, cnt_en=0, up_down=1, busy=0, done=0, err=0, sweep_cnt=0, latched bounds=0.
REQ-034 Reset mid-run aborts with no done pulse; first start is accepted on the first edge after reset deassertion.

Structure
REQ-035 Shared package holds the state enumeration and the W/CW default constants.
REQ-036 No sub-module; the counter is external, and the bench pairs sweep_ctrl with the team's 8-bit up/down counter (or a behavioural model with load/en).

Verification
REQ-037 lo=10, hi=13, cycles=2, start pulse -> cnt_q runs 10,11,12,13,12,11,10,11,12,13,12,11,10; done one cycle after the final 10; sweep_cnt=2.
REQ-038 lo=5, hi=5, start -> err pulse one cycle later, busy stays 0, cnt_load never asserted.
REQ-039 lo=0, hi=255, cycles=0, stop after 600 cycles -> wrap-free triangle 0..255..0, idle within one cycle, no done, sweep_cnt=1.
REQ-040 lo=3, hi=4, cycles=1 -> sequence 3,4,3, done; start re-asserted while busy has no effect.
REQ-041 Reset asserted in RUN_DOWN of lo=20, hi=30 -> outputs at reset values immediately; a fresh start after release runs a full sweep.
REQ-042 stop in the same cycle as the terminal condition (lo=1, hi=3, cycles=1) -> no done pulse, sweep_cnt=1, state IDLE.
